pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the five-stage MIPS core. It drives the enable and clear inputs of the PC and of the FD, DE, EM and MW pipeline registers. It resolves hazard stalls, multiply/divide-unit occupancy and exception/interrupt flushes in a fixed priority order. It owns the MDU busy state machine and two 32-bit performance counters, which expose stall and flush activity to CP0/debug logic.

## Interface
Parameters:
- MULT_CYCLES, 5: busy duration of mult/multu, in cycles (≥1).
- DIV_CYCLES, 10: busy duration of div/divu, in cycles (≥1).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; all state cleared on the rising edge where it is sampled high.
- D_stall_hazard  input  1  data-hazard stall request from the D-stage T_use/T_new comparator.
- D_md_use  input  1  D-stage instruction is an MDU instruction (mult/div/mfhi/mflo/mthi/mtlo).
- E_md_start  input  1  E-stage instruction launches an MDU operation this cycle.
- E_md_is_div  input  1  qualifies E_md_start: 1 = divide, 0 = multiply.
- M_req  input  1  exception/interrupt commit request from CP0 in M.
- pc_en  output  1  PC write enable.
- FD_en, DE_en, EM_en, MW_en  output  1 each  register enables.
- FD_clear, DE_clear, EM_clear, MW_clear  output  1 each  register clears.
- MW_req  output  1  Req to the MW register, which loads pc 32'h4180.
- E_md_busy  output  1  MDU occupied.
- md_done  output  1  one-cycle pulse on the last busy cycle.
- md_overlap_err  output  1  sticky; an MDU start arrived while busy.
- stall_cnt  output  32  count of stall cycles.
- flush_cnt  output  32  count of flush cycles.

## Operation
- MDU FSM states: IDLE, MUL, DIV; 4-bit down-counter cnt.
  - IDLE: E_md_start & !M_req goes to DIV if E_md_is_div, else MUL. cnt loads DIV_CYCLES or MULT_CYCLES.
  - MUL/DIV: cnt decrements each cycle. When cnt==1, return to IDLE.
  - M_req does not abort an operation already in progress, because that instruction has committed.
  - E_md_start while state≠IDLE is ignored, sets md_overlap_err, and leaves state unchanged.
- E_md_busy = (state≠IDLE). md_done = busy & (cnt==1).
- stall = D_stall_hazard | (D_md_use & (E_md_busy | E_md_start)).
- Output priority is reset > M_req > stall > run. All outputs are combinational from this decode.
  - reset: all four clears = 1, all enables = 1, pc_en = 1, MW_req = 0.
  - M_req: FD_clear = DE_clear = EM_clear = 1, MW_req = 1, MW_clear = 0, all enables = 1, pc_en = 1. PC load of the handler is done by the PC mux.
  - stall: pc_en = 0, FD_en = 0, DE_clear = 1, DE_en = 1, EM_en = MW_en = 1, all other clears = 0.
  - run: all enables = 1, all clears = 0, MW_req = 0.
- stall_cnt increments on each cycle with stall & !M_req & !reset.
- flush_cnt increments on each cycle with M_req & !reset.
- Both counters are 32-bit and wrap 0xFFFFFFFF→0.

## Timing
- Reset values: state IDLE, cnt 0, E_md_busy 0, md_done 0, md_overlap_err 0, stall_cnt 0, flush_cnt 0.
- MDU latency: a start sampled at edge t gives E_md_busy high for cycles t+1 … t+N exactly (N = MULT_CYCLES or DIV_CYCLES). md_done is high in cycle t+N. A new start is accepted at edge t+N.
- A start in the same cycle as M_req is dropped; busy stays 0.
- A D-stage MDU instruction behind a starting MDU instruction stalls from the start cycle through cycle t+N, and advances at edge t+N+1.
- Stall and flush outputs take effect in the cycle they are asserted; there is no registered delay.
- Reset mid-operation: at the reset edge, the FSM goes to IDLE and the counters clear.
- M_req during stall: the flush wins, and that cycle is counted only in flush_cnt.

## Test plan
- Reset held 2 cycles, then released -> all state 0. During reset, all clears = 1 and pc_en = 1. In the first run cycle, enables = 1 and clears = 0.
- E_md_start=1, E_md_is_div=0 at cycle 10 (MULT_CYCLES=5) -> E_md_busy high in cycles 11–15, md_done in cycle 15, busy low in cycle 16.
- Div start at cycle 3 with D_md_use=1 held -> pc_en=0, FD_en=0, DE_clear=1 in cycles 3–13. stall_cnt=11 afterward.
- D_stall_hazard=1 and M_req=1 in the same cycle -> FD/DE/EM_clear=1, MW_req=1, pc_en=1. flush_cnt increments by 1 and stall_cnt is unchanged.
- E_md_start with M_req in the same cycle -> busy stays 0. A second start during a running mult -> md_overlap_err=1, and the mult still ends at its original cycle.
- Preload stall_cnt to 0xFFFFFFFF via force, then one stall cycle -> stall_cnt = 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the five-stage MIPS core: PC / pipeline-register enables
// and clears, MDU occupancy tracking, and stall/flush performance counters.
module pipe_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_stall_hazard,
  input  logic        D_md_use,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        M_req,
  output logic        pc_en,
  output logic        FD_en,
  output logic        DE_en,
  output logic        EM_en,
  output logic        MW_en,
  output logic        FD_clear,
  output logic        DE_clear,
  output logic        EM_clear,
  output logic        MW_clear,
  output logic        MW_req,
  output logic        E_md_busy,
  output logic        md_done,
  output logic        md_overlap_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        overlap_q, overlap_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic busy;
  logic md_last;
  logic md_accept;
  logic stall;

  assign busy    = (state_q != IDLE);
  assign md_last = busy & (cnt_q == 4'd1);
  // The final busy cycle is also an acceptance point, so back-to-back MDU ops
  // leave no idle bubble; a start squashed by M_req never launches.
  assign md_accept = E_md_start & ~M_req & (~busy | md_last);
  assign stall     = D_stall_hazard | (D_md_use & (busy | E_md_start));

  // NOTE: every always_comb variable gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    overlap_d   = overlap_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (busy) begin
      cnt_d = cnt_q - 4'd1;
      if (md_last) begin
        state_d = IDLE;
      end
      if (E_md_start & ~md_last) begin
        overlap_d = 1'b1;
      end
    end

    if (md_accept) begin
      state_d = E_md_is_div ? DIV : MUL;
      cnt_d   = E_md_is_div ? DIV_LOAD : MULT_LOAD;
    end

    if (M_req) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Pipeline control decode: reset > M_req > stall > run, all combinational.
  always_comb begin
    pc_en    = 1'b1;
    FD_en    = 1'b1;
    DE_en    = 1'b1;
    EM_en    = 1'b1;
    MW_en    = 1'b1;
    FD_clear = 1'b0;
    DE_clear = 1'b0;
    EM_clear = 1'b0;
    MW_clear = 1'b0;
    MW_req   = 1'b0;

    if (reset) begin
      FD_clear = 1'b1;
      DE_clear = 1'b1;
      EM_clear = 1'b1;
      MW_clear = 1'b1;
    end else if (M_req) begin
      FD_clear = 1'b1;
      DE_clear = 1'b1;
      EM_clear = 1'b1;
      MW_req   = 1'b1;
    end else if (stall) begin
      pc_en    = 1'b0;
      FD_en    = 1'b0;
      DE_clear = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      overlap_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      overlap_q   <= overlap_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign E_md_busy      = busy;
  assign md_done        = md_last;
  assign md_overlap_err = overlap_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic,
// checked every cycle against a cycle-window model of the MDU and counters.
module tb_pipe_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, D_stall_hazard, D_md_use, E_md_start, E_md_is_div, M_req;
  logic        pc_en, FD_en, DE_en, EM_en, MW_en;
  logic        FD_clear, DE_clear, EM_clear, MW_clear, MW_req;
  logic        E_md_busy, md_done, md_overlap_err;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .D_stall_hazard(D_stall_hazard), .D_md_use(D_md_use),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .M_req(M_req),
    .pc_en(pc_en), .FD_en(FD_en), .DE_en(DE_en), .EM_en(EM_en), .MW_en(MW_en),
    .FD_clear(FD_clear), .DE_clear(DE_clear), .EM_clear(EM_clear), .MW_clear(MW_clear),
    .MW_req(MW_req), .E_md_busy(E_md_busy), .md_done(md_done),
    .md_overlap_err(md_overlap_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the MDU is busy during the cycle window [busy_lo, busy_hi].
  int          cyc     = 0;
  int          busy_lo = 0;
  int          busy_hi = -1;
  bit          m_ovl   = 1'b0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  logic [9:0]  last_ctrl;
  logic        last_busy, last_done;

  function automatic bit m_busy();
    return (cyc >= busy_lo) && (cyc <= busy_hi);
  endfunction

  function automatic bit m_done();
    return m_busy() && (cyc == busy_hi);
  endfunction

  function automatic bit m_stall_req();
    return D_stall_hazard | (D_md_use & (m_busy() | E_md_start));
  endfunction

  // {pc_en, FD_en, DE_en, EM_en, MW_en, FD_clear, DE_clear, EM_clear, MW_clear, MW_req}
  function automatic logic [9:0] exp_ctrl();
    if (reset)              return 10'b11111_1111_0;
    else if (M_req)         return 10'b11111_1110_1;
    else if (m_stall_req()) return 10'b00111_0100_0;
    else                    return 10'b11111_0000_0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic haz, input logic use_md,
                      input logic start, input logic is_div, input logic mreq);
    bit b, d, s;
    @(negedge clk);
    reset = rst; D_stall_hazard = haz; D_md_use = use_md;
    E_md_start = start; E_md_is_div = is_div; M_req = mreq;
    #1;
    last_ctrl = {pc_en, FD_en, DE_en, EM_en, MW_en, FD_clear, DE_clear, EM_clear, MW_clear, MW_req};
    last_busy = E_md_busy;
    last_done = md_done;
    check("ctrl",      32'(last_ctrl),      32'(exp_ctrl()));
    check("busy",      32'(E_md_busy),      32'(m_busy()));
    check("done",      32'(md_done),        32'(m_done()));
    check("overlap",   32'(md_overlap_err), 32'(m_ovl));
    check("stall_cnt", stall_cnt,           m_stall);
    check("flush_cnt", flush_cnt,           m_flush);
    b = m_busy();
    d = m_done();
    s = m_stall_req();
    @(posedge clk);
    if (rst) begin
      busy_lo = 0; busy_hi = -1; m_ovl = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
    end else begin
      if (start && b && !d) m_ovl = 1'b1;
      if (start && !mreq && (!b || d)) begin
        busy_lo = cyc + 1;
        busy_hi = cyc + (is_div ? DIV_N : MULT_N);
      end
      if (mreq)   m_flush = m_flush + 32'd1;
      else if (s) m_stall = m_stall + 32'd1;
    end
    cyc++;
  endtask

  initial begin
    int nb, nd, nstall, done_at;
    logic [31:0] s0, f0;

    reset = 1'b1; D_stall_hazard = 1'b0; D_md_use = 1'b0;
    E_md_start = 1'b0; E_md_is_div = 1'b0; M_req = 1'b0;
    @(posedge clk);

    // Reset held two cycles, then first run cycle.
    step(1, 0, 0, 0, 0, 0);
    check("rst_ctrl", 32'(last_ctrl), 32'(10'b11111_1111_0));
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("run_ctrl", 32'(last_ctrl), 32'(10'b11111_0000_0));

    // Single mult: busy for exactly MULT_N cycles, done on the last one.
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    nb = 0; done_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (last_busy) nb++;
      if (last_done) done_at = i;
    end
    check("mult_busy_len", 32'(nb), 32'(MULT_N));
    check("mult_done_at",  32'(done_at), 32'(MULT_N));

    // Div with a dependent MDU instruction held in D.
    s0 = m_stall; nstall = 0;
    step(0, 0, 1, 1, 1, 0);
    if (last_ctrl[9:8] == 2'b00 && last_ctrl[3]) nstall++;
    for (int i = 0; i < DIV_N + 2; i++) begin
      step(0, 0, 1, 0, 0, 0);
      if (last_ctrl[9:8] == 2'b00 && last_ctrl[3]) nstall++;
    end
    check("div_stall_cycles", 32'(nstall), 32'(DIV_N + 1));
    #1 check("div_stall_cnt", stall_cnt, s0 + 32'(DIV_N + 1));

    // Hazard and flush in the same cycle: flush wins, only flush_cnt moves.
    s0 = m_stall; f0 = m_flush;
    step(0, 1, 0, 0, 0, 1);
    check("flush_ctrl", 32'(last_ctrl), 32'(10'b11111_1110_1));
    #1;
    check("flush_cnt_inc", flush_cnt, f0 + 32'd1);
    check("stall_cnt_hold", stall_cnt, s0);

    // Start squashed by M_req, then overlap during a running mult.
    step(0, 0, 0, 1, 0, 1);
    #1 check("squash_busy", 32'(E_md_busy), 32'd0);
    step(0, 0, 0, 1, 0, 0);
    nb = 0; nd = -1;
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, (i == 2), 1'b1, 0);
      if (last_busy) nb++;
      if (last_done) nd = i;
    end
    check("ovl_busy_len", 32'(nb), 32'(MULT_N));
    check("ovl_done_at",  32'(nd), 32'(MULT_N));
    #1 check("ovl_flag", 32'(md_overlap_err), 32'd1);

    // Random traffic, including occasional mid-operation resets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
    end

    // Counter wrap from all-ones.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    #1 force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFF;
    step(0, 1, 0, 0, 0, 0);
    #1 check("stall_wrap", stall_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
